// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, mid-bit sample point and
// the parity helper that uart_tx uses as well.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } rx_state_e;

  function automatic int unsigned mid_of(input int unsigned cpb);
    return cpb / 2;
  endfunction

  // Parity bit a transmitter appends to make the frame even (odd=0) or odd (odd=1).
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO; head is popped when non-empty and ready_i is high.
// When empty, rdata_o keeps showing the last byte that was popped.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic [WIDTH-1:0] last_q;
  logic             pop, push_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign pop     = !empty_o && ready_i;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop);
  assign rdata_o = empty_o ? last_q : mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop) begin
        rd_q   <= rd_q + 1'b1;
        last_q <= mem_q[rd_q];
      end
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_framer.sv
// UART receiver: 8N1 / 8E1 / 8O1 with 3-sample majority vote, false-start
// rejection, frame/parity/overrun pulses and an output FIFO.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  input  logic       i_Rx_Ready,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Frame_Err,
  output logic       o_Parity_Err,
  output logic       o_Overrun,
  output logic       o_Busy
);

  localparam int unsigned MID = mid_of(CLKS_PER_BIT);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_S0   = CW'(MID - 1);
  localparam logic [CW-1:0] C_S1   = CW'(MID);
  localparam logic [CW-1:0] C_DEC  = CW'(MID + 1);
  localparam logic          ODD    = (PARITY_ODD != 0);

  rx_state_e     state_q;
  logic          rx_meta_q, rx_sync_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic [1:0]    samp_q;
  logic          par_ok_q, ferr_q, perr_q, ovr_q;
  logic          maj, at_last, at_dec, push_d, fifo_full, fifo_empty, pop;

  // Third sample is the live synchronised line at MID+1.
  assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q) | (samp_q[1] & rx_sync_q);
  assign at_last = (cnt_q == C_LAST);
  assign at_dec  = (cnt_q == C_DEC);
  assign push_d  = (state_q == ST_STOP) && at_dec && maj && par_ok_q;
  assign pop     = o_Rx_DV && i_Rx_Ready;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      samp_q    <= 2'b11;
      par_ok_q  <= 1'b1;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_sync_q <= rx_meta_q;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      ovr_q     <= push_d && fifo_full && !pop;
      cnt_q     <= at_last ? '0 : cnt_q + 1'b1;
      if (cnt_q == C_S0) samp_q[0] <= rx_sync_q;
      if (cnt_q == C_S1) samp_q[1] <= rx_sync_q;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (!rx_sync_q) state_q <= ST_START;
        end
        ST_START: begin
          if (at_dec && maj) state_q <= ST_IDLE;
          else if (at_last) begin
            state_q   <= ST_DATA;
            bit_idx_q <= '0;
            par_ok_q  <= 1'b1;
          end
        end
        ST_DATA: begin
          if (at_dec) shift_q <= {maj, shift_q[7:1]};
          if (at_last) begin
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_q <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (at_dec) par_ok_q <= (maj == parity_bit(shift_q, ODD));
          if (at_last) state_q <= ST_STOP;
        end
        ST_STOP: begin
          // Leave at mid-stop so the next start edge is not missed.
          if (at_dec) begin
            if (!maj) begin
              ferr_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= ST_BREAK_WAIT;
            end else begin
              perr_q  <= !par_ok_q;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_BREAK_WAIT: begin
          if (!rx_sync_q) cnt_q <= '0;
          else if (at_last) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (i_Clock),
    .rst_i   (i_Reset),
    .push_i  (push_d),
    .wdata_i (shift_q),
    .ready_i (i_Rx_Ready),
    .rdata_o (o_Rx_Byte),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign o_Rx_DV      = !fifo_empty;
  assign o_Frame_Err  = ferr_q;
  assign o_Parity_Err = perr_q;
  assign o_Overrun    = ovr_q;
  assign o_Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench: table of single frames on a no-parity and an even-parity
// receiver, plus hand sequences for glitch, break, overrun and mid-frame reset.
module tb_uart_rx_framer;

  localparam int CPB = 87;

  logic       clk = 1'b0;
  logic       rst, rdy;
  logic       rx [2];
  logic       dv [2], fe [2], pe [2], ov [2], bz [2];
  logic [7:0] rb [2];

  int         checks = 0, errors = 0;
  int         pops [2], ferrs [2], perrs [2], ovrs [2];
  logic [7:0] last [2];

  always #50 clk = ~clk;

  uart_rx_framer #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(4)) u0 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[0]), .o_Rx_DV(dv[0]), .i_Rx_Ready(rdy),
    .o_Rx_Byte(rb[0]), .o_Frame_Err(fe[0]), .o_Parity_Err(pe[0]), .o_Overrun(ov[0]), .o_Busy(bz[0]));

  uart_rx_framer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(4)) u1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[1]), .o_Rx_DV(dv[1]), .i_Rx_Ready(rdy),
    .o_Rx_Byte(rb[1]), .o_Frame_Err(fe[1]), .o_Parity_Err(pe[1]), .o_Overrun(ov[1]), .o_Busy(bz[1]));

  initial for (int k = 0; k < 2; k++) begin
    pops[k] = 0; ferrs[k] = 0; perrs[k] = 0; ovrs[k] = 0; last[k] = '0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (dv[k] && rdy) begin
          pops[k] <= pops[k] + 1;
          last[k] <= rb[k];
        end
        if (fe[k]) ferrs[k] <= ferrs[k] + 1;
        if (pe[k]) perrs[k] <= perrs[k] + 1;
        if (ov[k]) ovrs[k]  <= ovrs[k] + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input int k, input logic v);
    rx[k] = v;
    wait_clks(CPB);
  endtask

  // Leaves the line at the stop-bit level.
  task automatic send_frame(input int k, input logic [7:0] d, input logic pen,
                            input logic pbit, input logic stop);
    send_bit(k, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(k, d[i]);
    if (pen) send_bit(k, pbit);
    send_bit(k, stop);
  endtask

  typedef struct {
    int         d;
    logic [7:0] data;
    logic       pen, pbit, stop;
    int         exp_pops;
    logic [7:0] exp_byte;
    int         exp_ferr, exp_perr;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int p0, f0, q0, o0;
    vecs[0]  = '{0, 8'h3F, 0, 0, 1, 1, 8'h3F, 0, 0};
    vecs[1]  = '{0, 8'hA5, 0, 0, 1, 1, 8'hA5, 0, 0};
    vecs[2]  = '{0, 8'h00, 0, 0, 1, 1, 8'h00, 0, 0};
    vecs[3]  = '{0, 8'hFF, 0, 0, 1, 1, 8'hFF, 0, 0};
    vecs[4]  = '{0, 8'h55, 0, 0, 0, 0, 8'h00, 1, 0};
    vecs[5]  = '{0, 8'h12, 0, 0, 1, 1, 8'h12, 0, 0};
    vecs[6]  = '{1, 8'hAB, 1, 1, 1, 1, 8'hAB, 0, 0};
    vecs[7]  = '{1, 8'hAB, 1, 0, 1, 0, 8'h00, 0, 1};
    vecs[8]  = '{1, 8'h00, 1, 0, 1, 1, 8'h00, 0, 0};
    vecs[9]  = '{1, 8'h80, 1, 1, 1, 1, 8'h80, 0, 0};
    vecs[10] = '{1, 8'h80, 1, 0, 0, 0, 8'h00, 1, 0};
    vecs[11] = '{1, 8'h3C, 1, 0, 1, 1, 8'h3C, 0, 0};

    rst = 1'b1; rdy = 1'b1; rx[0] = 1'b1; rx[1] = 1'b1;
    wait_clks(3);
    chk("reset dv", dv[0], 0);
    chk("reset byte", rb[0], 0);
    chk("reset busy", bz[0], 0);
    chk("reset pulses", {fe[0], pe[0], ov[0]}, 0);
    chk("reset dv parity dut", dv[1], 0);
    rst = 1'b0;
    wait_clks(5);

    for (int v = 0; v < 12; v++) begin
      int d;
      d  = vecs[v].d;
      p0 = pops[d]; f0 = ferrs[d]; q0 = perrs[d];
      send_frame(d, vecs[v].data, vecs[v].pen, vecs[v].pbit, vecs[v].stop);
      rx[d] = 1'b1;
      wait_clks(2 * CPB);
      chk($sformatf("vec%0d dv count", v), pops[d] - p0, vecs[v].exp_pops);
      chk($sformatf("vec%0d frame err", v), ferrs[d] - f0, vecs[v].exp_ferr);
      chk($sformatf("vec%0d parity err", v), perrs[d] - q0, vecs[v].exp_perr);
      chk($sformatf("vec%0d busy", v), bz[d], 0);
      if (vecs[v].exp_pops != 0) chk($sformatf("vec%0d byte", v), last[d], vecs[v].exp_byte);
    end

    // Short low glitch is rejected as a false start.
    p0 = pops[0]; f0 = ferrs[0]; q0 = perrs[0];
    rx[0] = 1'b0;
    wait_clks(10);
    chk("glitch busy", bz[0], 1);
    wait_clks(10);
    rx[0] = 1'b1;
    wait_clks(50);
    chk("glitch idle before bit end", bz[0], 0);
    wait_clks(CPB);
    chk("glitch no dv", pops[0] - p0, 0);
    chk("glitch no pulses", (ferrs[0] - f0) + (perrs[0] - q0), 0);

    // Long break after a bad stop bit: a single frame error.
    p0 = pops[0]; f0 = ferrs[0];
    send_frame(0, 8'h55, 0, 0, 0);
    wait_clks(3 * CPB);
    chk("break busy", bz[0], 1);
    rx[0] = 1'b1;
    wait_clks(2 * CPB);
    chk("break frame err", ferrs[0] - f0, 1);
    chk("break no dv", pops[0] - p0, 0);
    chk("break idle", bz[0], 0);
    send_frame(0, 8'h12, 0, 0, 1);
    wait_clks(2 * CPB);
    chk("after break dv", pops[0] - p0, 1);
    chk("after break byte", last[0], 8'h12);

    // Overrun: FIFO of 4 with consumer stalled.
    rdy = 1'b0;
    o0 = ovrs[0];
    for (int b = 1; b <= 5; b++) begin
      send_frame(0, 8'(b), 0, 0, 1);
      wait_clks(CPB);
      if (b == 4) begin
        chk("ovr none at 4", ovrs[0] - o0, 0);
        chk("ovr head", rb[0], 8'h01);
      end
    end
    chk("ovr once", ovrs[0] - o0, 1);
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("drain%0d dv", i), dv[0], 1);
      chk($sformatf("drain%0d byte", i), rb[0], 8'(i + 1));
    end
    @(negedge clk);
    chk("drain empty", dv[0], 0);
    wait_clks(2);

    // Reset mid-frame discards the partial byte and empties the FIFO.
    rdy = 1'b0;
    send_frame(0, 8'h77, 0, 0, 1);
    wait_clks(CPB);
    chk("pre-reset dv", dv[0], 1);
    chk("pre-reset byte", rb[0], 8'h77);
    f0 = ferrs[0]; q0 = perrs[0]; o0 = ovrs[0];
    send_bit(0, 1'b0);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    rx[0] = 1'b1;
    wait_clks(40);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    chk("midreset dv", dv[0], 0);
    chk("midreset byte", rb[0], 0);
    chk("midreset busy", bz[0], 0);
    chk("midreset pulses", {fe[0], pe[0], ov[0]}, 0);
    wait_clks(2 * CPB);
    chk("midreset no later pulses", (ferrs[0] - f0) + (perrs[0] - q0) + (ovrs[0] - o0), 0);
    chk("midreset still empty", dv[0], 0);
    rdy = 1'b1;
    p0 = pops[0];
    send_frame(0, 8'hC3, 0, 0, 1);
    wait_clks(2 * CPB);
    chk("post-reset dv", pops[0] - p0, 1);
    chk("post-reset byte", last[0], 8'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
Robust UART receiver (8 data bits, optional parity, 1 stop bit) that decodes the serial stream produced by uart_tx. It adds majority-vote sampling, false-start rejection, framing/parity error detection and a small output FIFO with valid/ready handshake. It sits between the pad-side serial input and the command-parsing logic, replacing direct use of a single-byte DV pulse where the consumer can stall.

Parameters:
CLKS_PER_BIT, 87, clocks per bit (10 MHz / 115200); must be >= 8
PARITY_EN, 0, 1 = a parity bit follows data bit 7
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2

Ports:
i_Clock  in  1  system clock
i_Reset  in  1  synchronous, active-high reset
i_Rx_Serial  in  1  asynchronous serial line; idle high
o_Rx_DV  out  1  FIFO non-empty; o_Rx_Byte valid
i_Rx_Ready  in  1  consumer accepts head byte when o_Rx_DV=1
o_Rx_Byte  out  8  FIFO head byte
o_Frame_Err  out  1  1-cycle pulse: stop bit sampled 0
o_Parity_Err  out  1  1-cycle pulse: parity mismatch
o_Overrun  out  1  1-cycle pulse: good byte dropped, FIFO full
o_Busy  out  1  high while the FSM is not IDLE

Behaviour:
- Reset (synchronous, i_Reset=1 at a clock edge): FSM to IDLE, synchroniser flops to 1, FIFO emptied. o_Rx_DV=0, o_Rx_Byte=0, all error pulses 0, o_Busy=0. A reset mid-frame discards the partial byte with no error pulse.
- Input: 2-flop synchroniser; the FSM sees the line 2 cycles late.
- Sampling: within each bit, three samples at counts MID-1, MID, MID+1 (MID = CLKS_PER_BIT/2). Bit value is the 2-of-3 majority. The bit counter runs 0..CLKS_PER_BIT-1, then wraps.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- IDLE -> START: on synchronised line = 0. The counter clears.
- START: if majority = 1 at MID+1, false start -> IDLE with no pulse. Otherwise continue to the bit end -> DATA.
- DATA: 8 bits, LSB first, shifted in. After bit 7 -> PARITY if PARITY_EN, else STOP.
- PARITY: for even parity, the XOR of the 8 data bits and the parity bit must be 0; for odd parity it must be 1. The result is held until STOP.
- STOP: decision at MID+1 of the stop bit; then immediately IDLE, so back-to-back frames resynchronise on the next start edge.
  - Stop = 0: o_Frame_Err pulses, byte discarded -> BREAK_WAIT. This takes priority over a parity error.
  - Stop = 1 with parity bad: o_Parity_Err pulses, byte discarded -> IDLE.
  - Stop = 1 with parity good: push the byte. If the FIFO is full and no pop occurs that cycle, drop it and pulse o_Overrun.
- BREAK_WAIT: stay until the line samples 1 for one full bit period, then IDLE. There are no further pulses during a long break.
- FIFO: a push becomes visible on o_Rx_DV/o_Rx_Byte on the cycle after the push. A pop occurs when o_Rx_DV && i_Rx_Ready. Simultaneous push and pop on a full FIFO are both accepted and the count is unchanged. Pop on empty is ignored. Pointers wrap modulo FIFO_DEPTH. o_Rx_Byte holds the last head value when empty.
- Latency: from the line's stop-bit leading edge, o_Rx_DV rises at 2 + MID + 2 cycles.

Decomposition:
- Shared uart_pkg include: state encodings, MID constant function, parity helper function. uart_tx reuses the parity helper.
- One sub-module, uart_sync_fifo (width 8, depth FIFO_DEPTH, valid/ready pop, full/empty flags), instantiated once.

Test Plan:
All scenarios use a 100 ns clock, CLKS_PER_BIT=87, and an 8700 ns bit period.
1. Send 0x3F with i_Rx_Ready=1 -> exactly one o_Rx_DV cycle with o_Rx_Byte=0x3F; no error pulses; o_Busy=0 after the stop bit.
2. Pulse the line low for 20 clocks, then return high -> no DV, no error pulse; FSM back in IDLE before bit end.
3. Send 0x55 with stop bit 0, then hold low for 3 bit periods, then high -> one o_Frame_Err pulse, nothing pushed. A following 0x12 is received correctly.
4. Hold i_Rx_Ready=0 and send 0x01..0x05 -> o_Overrun pulses once, on the 5th byte. Raising ready then pops 0x01, 0x02, 0x03, 0x04 on consecutive cycles, then o_Rx_DV=0.
5. PARITY_EN=1, even: send 0xAB with parity bit 1 -> received 0xAB. Send 0xAB with parity bit 0 -> o_Parity_Err pulse, no DV.
6. Assert i_Reset for 1 cycle during data bit 3 of 0x9A -> all outputs reset, FIFO empty, no pulses. Next frame 0xC3 is received correctly.
